// File: rtl/bitcell_serial_reader.sv
// Captures one parallel word from the bitcells and streams it LSB first over a valid/ready link.
// Define PARITY_EN to append an even-parity bit after the data bits.
module bitcell_serial_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);

`ifdef PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBITS - 1);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] sreg;
  logic [NBITS-1:0] load_word;
  logic [CNT_W-1:0] cnt;
  logic             at_last;
  logic             load_fire;
  logic             xfer_fire;

`ifdef PARITY_EN
  // Parity rides in the top of the shift register so it falls out right after the data.
  assign load_word = {^load_data, load_data};
`else
  assign load_word = load_data;
`endif

  assign at_last = (cnt == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    ser_valid  = 1'b0;
    ser_out    = 1'b0;
    ser_last   = 1'b0;
    load_fire  = 1'b0;
    xfer_fire  = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        load_fire  = load_valid;
        if (load_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_out   = sreg[0];
        ser_last  = at_last;
        xfer_fire = ser_ready;
        if (ser_ready && at_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load_fire) begin
      sreg <= load_word;
      cnt  <= '0;
    end else if (xfer_fire) begin
      sreg <= {1'b0, sreg[NBITS-1:1]};
      cnt  <= at_last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule
